// File: rtl/ar_access_ctrl_if.sv
// Request, memory-handshake and register-enable bundle around the AR access sequencer.
// The sequencer takes the slave view; requesters and memory take the master view.
interface ar_access_ctrl_if;
   logic fetch_req;
   logic data_req;
   logic data_we;
   logic data_imm;
   logic mem_ready;
   logic ar_wen;
   logic ar_sel;
   logic mem_rd;
   logic mem_wr;
   logic ir_wen;
   logic dr_wen;
   logic pc_inc;
   logic fetch_done;
   logic data_done;
   logic busy;
   logic err;

   modport master (
      output fetch_req, data_req, data_we, data_imm, mem_ready,
      input  ar_wen, ar_sel, mem_rd, mem_wr, ir_wen, dr_wen,
             pc_inc, fetch_done, data_done, busy, err
   );

   modport slave (
      input  fetch_req, data_req, data_we, data_imm, mem_ready,
      output ar_wen, ar_sel, mem_rd, mem_wr, ir_wen, dr_wen,
             pc_inc, fetch_done, data_done, busy, err
   );
endinterface

// File: rtl/ar_access_ctrl.sv
// AR/memory access sequencer: arbitrates fetch vs data, loads AR, strobes memory, pulses IR/DR capture.
// Optional memory timeout abort is enabled by defining MEM_TIMEOUT_EN.
module ar_access_ctrl #(
   parameter int unsigned MAX_DATA_RUN = 3,
   parameter int unsigned TIMEOUT_CYC  = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic              Clk,
   input  logic              Rst_n,
   ar_access_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_AR = 2'd1,
      ACCESS  = 2'd2,
      DONE    = 2'd3
   } state_t;

   if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC >= (1 << CNT_W)) || (MAX_DATA_RUN >= (1 << CNT_W))) begin : g_cfg_err
      $error("ar_access_ctrl: CNT_W too narrow for TIMEOUT_CYC or MAX_DATA_RUN");
   end

   state_t             state_r;
   state_t             state_nxt_s;
   logic [CNT_W-1:0]   run_r;
   logic               run_at_max_s;
   logic               grant_data_s;
   logic               grant_fetch_s;
   logic               tmo_hit_s;
   logic               is_data_r;
   logic               we_r;
   logic               store_s;
   logic               ar_wen_r;
   logic               ar_sel_r;
   logic               mem_rd_r;
   logic               mem_wr_r;
   logic               pc_inc_r;
   logic               fetch_done_r;
   logic               data_done_r;
   logic               busy_r;

   assign run_at_max_s = (run_r == CNT_W'(MAX_DATA_RUN));
   assign store_s      = is_data_r & we_r;

`ifdef MEM_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0]   tmo_r;
   logic               err_r;

   assign tmo_hit_s = (tmo_r == TMO_LAST);

   // Timeout counter (cleared entering ACCESS) and registered abort flag shown in DONE
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         tmo_r <= {CNT_W{1'b0}};
         err_r <= 1'b0;
      end else begin
         if (state_r == LOAD_AR) begin
            tmo_r <= {CNT_W{1'b0}};
         end else if ((state_r == ACCESS) && !bus.mem_ready && !tmo_hit_s) begin
            tmo_r <= tmo_r + CNT_W'(1);
         end
         err_r <= (state_r == ACCESS) && !bus.mem_ready && tmo_hit_s;
      end
   end

   assign bus.err = err_r;
`else
   assign tmo_hit_s = 1'b0;
   assign bus.err   = 1'b0;
`endif

   // Next-state and grant decode; requests are only looked at in IDLE
   always_comb begin
      state_nxt_s   = state_r;
      grant_data_s  = 1'b0;
      grant_fetch_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.data_req && !(run_at_max_s && bus.fetch_req)) begin
               grant_data_s = 1'b1;
               state_nxt_s  = LOAD_AR;
            end else if (bus.fetch_req) begin
               grant_fetch_s = 1'b1;
               state_nxt_s   = LOAD_AR;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD_AR: state_nxt_s = ACCESS;
         ACCESS: begin
            if (bus.mem_ready || tmo_hit_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = ACCESS;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register plus the access context latched at grant
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r   <= IDLE;
         run_r     <= {CNT_W{1'b0}};
         is_data_r <= 1'b0;
         we_r      <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (grant_data_s) begin
            is_data_r <= 1'b1;
            we_r      <= bus.data_we;
            run_r     <= run_at_max_s ? run_r : (run_r + CNT_W'(1));
         end else if (grant_fetch_s) begin
            is_data_r <= 1'b0;
            we_r      <= 1'b0;
            run_r     <= {CNT_W{1'b0}};
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state they belong to
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ar_wen_r     <= 1'b0;
         ar_sel_r     <= 1'b0;
         mem_rd_r     <= 1'b0;
         mem_wr_r     <= 1'b0;
         pc_inc_r     <= 1'b0;
         fetch_done_r <= 1'b0;
         data_done_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         ar_wen_r     <= (state_nxt_s == LOAD_AR);
         ar_sel_r     <= (state_nxt_s == LOAD_AR) && grant_data_s && bus.data_imm;
         mem_rd_r     <= (state_nxt_s == ACCESS) && !store_s;
         mem_wr_r     <= (state_nxt_s == ACCESS) && store_s;
         pc_inc_r     <= (state_nxt_s == DONE) && !is_data_r;
         fetch_done_r <= (state_nxt_s == DONE) && !is_data_r;
         data_done_r  <= (state_nxt_s == DONE) && is_data_r;
         busy_r       <= (state_nxt_s != IDLE);
      end
   end

   assign bus.ar_wen     = ar_wen_r;
   assign bus.ar_sel     = ar_sel_r;
   assign bus.mem_rd     = mem_rd_r;
   assign bus.mem_wr     = mem_wr_r;
   assign bus.pc_inc     = pc_inc_r;
   assign bus.fetch_done = fetch_done_r;
   assign bus.data_done  = data_done_r;
   assign bus.busy       = busy_r;

   // Capture enables must land on the very edge that completes the read
   assign bus.ir_wen = (state_r == ACCESS) && bus.mem_ready && !is_data_r;
   assign bus.dr_wen = (state_r == ACCESS) && bus.mem_ready && is_data_r && !we_r;

endmodule

// File: tb/tb_ar_access_ctrl.sv
// Scoreboard bench for ar_access_ctrl: randomized requesters and memory, transaction-level reference model.
// Timeout-specific scenarios are selected by MEM_TIMEOUT_EN, matching the RTL build.
module tb_ar_access_ctrl;

   localparam int MAX_RUN = 3;
   localparam int TMO     = 16;

   typedef struct {
      bit is_data;
      bit sel;
      bit wr;
      int strobes;
      bit err;
   } exp_t;

   logic Clk;
   logic Rst_n;
   ar_access_ctrl_if bus_if ();

   ar_access_ctrl #(.MAX_DATA_RUN(MAX_RUN), .TIMEOUT_CYC(TMO), .CNT_W(5)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus_if)
   );

   exp_t  exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    model_run = 0;
   int    cur_waits = 0;
   string grant_log = "";

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [10:0] all_outs();
      return {bus_if.ar_wen, bus_if.ar_sel, bus_if.mem_rd, bus_if.mem_wr, bus_if.ir_wen,
              bus_if.dr_wen, bus_if.pc_inc, bus_if.fetch_done, bus_if.data_done,
              bus_if.busy, bus_if.err};
   endfunction

   // Memory: completes after cur_waits wait states; random ready noise while no strobe is up
   initial begin
      int wcnt;
      wcnt = 0;
      bus_if.mem_ready = 1'b0;
      forever begin
         @(negedge Clk);
         if (bus_if.mem_rd || bus_if.mem_wr) begin
            bus_if.mem_ready = (wcnt == cur_waits);
            wcnt++;
         end else begin
            bus_if.mem_ready = 1'($urandom_range(0, 1));
            wcnt = 0;
         end
      end
   end

   // Monitor: assembles one access from the observed pulses, checks it on the done pulse
   initial begin
      int ar_cnt, rd_cnt, wr_cnt, ir_cnt, dr_cnt, busy_cnt, cap_at;
      bit sel_seen;
      exp_t e;
      ar_cnt = 0; rd_cnt = 0; wr_cnt = 0; ir_cnt = 0; dr_cnt = 0; busy_cnt = 0; cap_at = 0;
      sel_seen = 1'b0;
      forever begin
         @(negedge Clk);
         #2;
         if (!Rst_n) begin
            ar_cnt = 0; rd_cnt = 0; wr_cnt = 0; ir_cnt = 0; dr_cnt = 0; busy_cnt = 0; cap_at = 0;
         end else begin
            if (bus_if.busy) busy_cnt++;
            if (bus_if.ar_wen) begin ar_cnt++; sel_seen = bus_if.ar_sel; end
            if (bus_if.mem_rd) rd_cnt++;
            if (bus_if.mem_wr) wr_cnt++;
            if (bus_if.ir_wen) begin ir_cnt++; cap_at = rd_cnt; end
            if (bus_if.dr_wen) begin dr_cnt++; cap_at = rd_cnt; end
            if (bus_if.fetch_done || bus_if.data_done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_kind", {bus_if.fetch_done, bus_if.data_done}, e.is_data ? 32'd1 : 32'd2);
                  check("ar_wen_cycles", ar_cnt, 32'd1);
                  check("ar_sel", sel_seen, e.sel);
                  check("mem_rd_cycles", rd_cnt, e.wr ? 0 : e.strobes);
                  check("mem_wr_cycles", wr_cnt, e.wr ? e.strobes : 0);
                  check("ir_wen_cycles", ir_cnt, (!e.is_data && !e.err) ? 1 : 0);
                  check("dr_wen_cycles", dr_cnt, (e.is_data && !e.wr && !e.err) ? 1 : 0);
                  if (!e.wr && !e.err) check("capture_cycle", cap_at, e.strobes);
                  check("pc_inc", bus_if.pc_inc, !e.is_data);
                  check("err", bus_if.err, e.err);
                  check("busy_cycles", busy_cnt, e.strobes + 2);
                  grant_log = {grant_log, bus_if.data_done ? "D" : "F"};
               end
               ar_cnt = 0; rd_cnt = 0; wr_cnt = 0; ir_cnt = 0; dr_cnt = 0; busy_cnt = 0; cap_at = 0;
            end
         end
      end
   end

   // Raise requests and record the access the reference model says will be granted
   task automatic start_txn(input bit f, input bit d, input bit we, input bit imm, input int waits);
      exp_t e;
      bit gd;
      @(negedge Clk);
      bus_if.fetch_req = f;
      bus_if.data_req  = d;
      bus_if.data_we   = we;
      bus_if.data_imm  = imm;
      cur_waits        = waits;
      gd = d && !(model_run == MAX_RUN && f);
      if (gd) model_run = (model_run < MAX_RUN) ? model_run + 1 : MAX_RUN;
      else    model_run = 0;
      e.is_data = gd;
      e.sel     = gd && imm;
      e.wr      = gd && we;
      e.strobes = waits + 1;
      e.err     = 1'b0;
`ifdef MEM_TIMEOUT_EN
      if (waits >= TMO) begin
         e.strobes = TMO;
         e.err     = 1'b1;
      end
`endif
      exp_q.push_back(e);
      @(negedge Clk);
      bus_if.data_we  = 1'($urandom_range(0, 1));
      bus_if.data_imm = 1'($urandom_range(0, 1));
   endtask

   // Wait for the done pulse and drop only the served request
   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge Clk);
         if (bus_if.fetch_done || bus_if.data_done) begin
            seen = 1'b1;
            if (bus_if.data_done) bus_if.data_req = 1'b0;
            else                  bus_if.fetch_req = 1'b0;
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      bus_if.fetch_req = 1'b0;
      bus_if.data_req  = 1'b0;
      exp_q.delete();
      model_run = 0;
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   initial begin
      bit f, d;
      Rst_n            = 1'b0;
      bus_if.fetch_req = 1'b0;
      bus_if.data_req  = 1'b0;
      bus_if.data_we   = 1'b0;
      bus_if.data_imm  = 1'b0;
      repeat (3) @(negedge Clk);
      #1;
      check("reset_outputs", all_outs(), 32'd0);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      #1;
      check("idle_outputs", all_outs(), 32'd0);

      // both requesters hold and re-raise: data wins until the run limit, then fetch
      grant_log = "";
      for (int i = 0; i < 8; i++) begin
         start_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
         wait_done();
      end
      #3;
      n_cmp++;
      if (grant_log != "DDDFDDDF") begin
         n_err++;
         $display("FAIL grant_order: got %s expected DDDFDDDF", grant_log);
      end

      // directed: fetch immediate, load with imm and 3 waits, store via bus
      start_txn(1'b1, 1'b0, 1'b0, 1'b0, 0); wait_done();
      start_txn(1'b0, 1'b1, 1'b0, 1'b1, 3); wait_done();
      start_txn(1'b0, 1'b1, 1'b1, 1'b0, 2); wait_done();

      for (int i = 0; i < 60; i++) begin
         f = bus_if.fetch_req | 1'($urandom_range(0, 1));
         d = bus_if.data_req  | 1'($urandom_range(0, 1));
         if (!f && !d) f = 1'b1;
         start_txn(f, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3));
         wait_done();
      end

      // reset in the middle of an access
      bus_if.fetch_req = 1'b0;
      bus_if.data_req  = 1'b0;
      start_txn(1'b1, 1'b0, 1'b0, 1'b0, 1000);
      for (int i = 0; i < 20 && !bus_if.mem_rd; i++) @(negedge Clk);
      repeat (2) @(negedge Clk);
      check("strobe_before_reset", bus_if.mem_rd, 32'd1);
      #1;
      Rst_n = 1'b0;
      #1;
      check("async_strobe_drop", {bus_if.mem_rd, bus_if.busy}, 32'd0);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         #1;
         check("post_reset_outputs", all_outs(), 32'd0);
      end

`ifdef MEM_TIMEOUT_EN
      start_txn(1'b0, 1'b1, 1'b0, 1'b0, 40); wait_done();
      start_txn(1'b1, 1'b0, 1'b0, 1'b0, 20); wait_done();
      start_txn(1'b0, 1'b1, 1'b0, 1'b1, 15); wait_done();
`else
      begin
         int dones;
         dones = 0;
         start_txn(1'b0, 1'b1, 1'b0, 1'b0, 100000);
         repeat (101) begin
            @(negedge Clk);
            if (bus_if.data_done || bus_if.fetch_done) dones++;
         end
         check("still_in_access", {bus_if.mem_rd, bus_if.busy, bus_if.err}, 32'd6);
         check("no_done_while_waiting", dones, 32'd0);
         do_reset();
      end
`endif

      repeat (4) @(negedge Clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
